// File: rtl/nic_pkg.sv
// Shared constants for the NIC: CPU register map and status-word bit positions.
package nic_pkg;

    localparam logic [1:0] NIC_ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

    // Bit 0 carries non-empty (input status) or full (output status); drop sits in the MSB.
    localparam int unsigned STAT_VALID_BIT = 0;
    localparam int unsigned STAT_DROP_BIT  = 63;

endpackage

// File: rtl/nic_sync_fifo.sv
// Synchronous FIFO with explicit occupancy count; head is presented combinationally.
module nic_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    // Full/empty come from the start-of-cycle count, so a push into a full FIFO is refused
    // even when a pop happens in the same cycle.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nic_fifo.sv
// NIC between a processing element and its router port: DEPTH-entry FIFOs each way,
// CPU register decode, router send strobe and a sticky write-drop flag.
module nic_fifo
    import nic_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = 64,
    parameter int unsigned DEPTH        = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              addr,
    input  logic [PACKET_WIDTH-1:0] d_in,
    output logic [PACKET_WIDTH-1:0] d_out,
    input  logic                    nicEn,
    input  logic                    nicEnWR,
    input  logic                    net_si,
    output logic                    net_ri,
    input  logic [PACKET_WIDTH-1:0] net_di,
    output logic                    net_so,
    input  logic                    net_ro,
    output logic [PACKET_WIDTH-1:0] net_do,
    input  logic                    net_polarity
);

    localparam int unsigned DROP_BIT = PACKET_WIDTH - 1;

    logic [PACKET_WIDTH-1:0] d_out_q, d_out_d;
    logic [PACKET_WIDTH-1:0] net_do_q, net_do_d;
    logic                    net_so_q, net_so_d;
    logic                    drop_q, drop_d;

    logic [PACKET_WIDTH-1:0] in_rdata, out_rdata;
    logic [CW-1:0]           in_count, out_count;
    logic                    in_full, in_empty, out_full, out_empty;
    logic                    cpu_rd, cpu_wr, in_push, in_pop, out_push, send;

    nic_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (net_di),
        .rdata (in_rdata),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    nic_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .pop   (send),
        .wdata (d_in),
        .rdata (out_rdata),
        .count (out_count),
        .full  (out_full),
        .empty (out_empty)
    );

    assign net_ri = !in_full;

    // CPU decode, status words, send and drop flag; drop set beats the clear-on-read.
    always_comb begin
        cpu_rd   = nicEn && !nicEnWR;
        cpu_wr   = nicEn && nicEnWR;
        in_push  = net_si && !in_full;
        in_pop   = cpu_rd && (addr == NIC_ADDR_IN_DATA) && !in_empty;
        out_push = cpu_wr && (addr == NIC_ADDR_OUT_DATA) && !out_full;
        send     = !out_empty && net_ro && net_polarity;
        d_out_d  = d_out_q;
        drop_d   = drop_q;
        if (cpu_rd) begin
            d_out_d = '0;
            case (addr)
                NIC_ADDR_IN_DATA: begin
                    if (!in_empty) d_out_d = in_rdata;
                end
                NIC_ADDR_IN_STAT: begin
                    d_out_d[CW:1]           = in_count;
                    d_out_d[STAT_VALID_BIT] = !in_empty;
                end
                NIC_ADDR_OUT_STAT: begin
                    d_out_d[DROP_BIT]       = drop_q;
                    d_out_d[CW:1]           = out_count;
                    d_out_d[STAT_VALID_BIT] = out_full;
                    drop_d                  = 1'b0;
                end
                default: d_out_d = '0;
            endcase
        end
        if (cpu_wr && (addr == NIC_ADDR_OUT_DATA) && out_full) begin
            drop_d = 1'b1;
        end
        net_so_d = send;
        net_do_d = send ? out_rdata : net_do_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out_q  <= '0;
            net_do_q <= '0;
            net_so_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            d_out_q  <= d_out_d;
            net_do_q <= net_do_d;
            net_so_q <= net_so_d;
            drop_q   <= drop_d;
        end
    end

    assign d_out  = d_out_q;
    assign net_do = net_do_q;
    assign net_so = net_so_q;

endmodule

// File: tb/tb_nic_fifo.sv
// Bench for nic_fifo: queue-based reference model compared every cycle, plus directed
// scenarios with literal expectations and a randomized soak.
module tb_nic_fifo;

    localparam int unsigned PW    = 64;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    addr;
    logic [PW-1:0] d_in, d_out, net_di, net_do;
    logic          nicEn, nicEnWR, net_si, net_ri, net_so, net_ro, net_polarity;

    int n_checks;
    int n_fail;

    nic_fifo #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWR      (nicEnWR),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two queues and the register semantics of the CPU map.
    logic [PW-1:0] m_inq[$];
    logic [PW-1:0] m_outq[$];
    logic [PW-1:0] m_dout, m_ndo;
    logic          m_nso, m_drop;
    bit            started = 1'b0;

    always @(posedge clk) begin
        int unsigned in_cnt, out_cnt;
        logic rd, wr;
        if (reset) begin
            m_inq.delete();
            m_outq.delete();
            m_dout = '0;
            m_ndo  = '0;
            m_nso  = 1'b0;
            m_drop = 1'b0;
        end else begin
            in_cnt  = $unsigned(m_inq.size());
            out_cnt = $unsigned(m_outq.size());
            rd = nicEn && !nicEnWR;
            wr = nicEn && nicEnWR;
            if (rd) begin
                case (addr)
                    2'd0: m_dout = (in_cnt != 0) ? m_inq.pop_front() : '0;
                    2'd1: m_dout = (PW'(in_cnt) << 1) | PW'(in_cnt != 0);
                    2'd2: m_dout = '0;
                    default: begin
                        m_dout = (PW'(m_drop) << (PW - 1)) | (PW'(out_cnt) << 1) | PW'(out_cnt == DEPTH);
                        m_drop = 1'b0;
                    end
                endcase
            end
            if (out_cnt != 0 && net_ro && net_polarity) begin
                m_ndo = m_outq.pop_front();
                m_nso = 1'b1;
            end else begin
                m_nso = 1'b0;
            end
            if (wr && addr == 2'd2) begin
                if (out_cnt != DEPTH) m_outq.push_back(d_in);
                else m_drop = 1'b1;
            end
            if (net_si && in_cnt != DEPTH) m_inq.push_back(net_di);
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_d_out", d_out, m_dout);
            chk("model_net_so", PW'(net_so), PW'(m_nso));
            chk("model_net_do", net_do, m_ndo);
            chk("model_net_ri", PW'(net_ri), PW'(m_inq.size() != DEPTH));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [PW-1:0] v);
        nicEn = 1'b1; nicEnWR = 1'b0; addr = a;
        step();
        nicEn = 1'b0;
        v = d_out;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [PW-1:0] v);
        nicEn = 1'b1; nicEnWR = 1'b1; addr = a; d_in = v;
        step();
        nicEn = 1'b0; nicEnWR = 1'b0;
    endtask

    task automatic router_push(input logic [PW-1:0] v);
        net_si = 1'b1; net_di = v;
        step();
        net_si = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] v;
        logic [PW-1:0] got[$];
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b0; nicEnWR = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state
        cpu_read(2'd1, v);
        chk("rst_stat01", v, 64'h0);
        chk("rst_net_ri", PW'(net_ri), 64'h1);
        chk("rst_net_so", PW'(net_so), 64'h0);

        // All-zero packet is legal; order and empty-read behaviour
        router_push(64'h0);
        router_push(64'hA5);
        cpu_read(2'd1, v); chk("in_stat_two", v, 64'h5);
        cpu_read(2'd0, v); chk("in_read_zero", v, 64'h0);
        cpu_read(2'd0, v); chk("in_read_a5", v, 64'hA5);
        cpu_read(2'd0, v); chk("in_read_empty", v, 64'h0);
        cpu_read(2'd1, v); chk("in_stat_empty", v, 64'h0);

        // Input back-pressure
        for (int k = 0; k < DEPTH; k++) router_push(PW'(32'h100 + k));
        chk("in_full_ri", PW'(net_ri), 64'h0);
        net_si = 1'b1; net_di = 64'h105;
        step(); step();
        chk("in_held_ri", PW'(net_ri), 64'h0);
        nicEn = 1'b1; nicEnWR = 1'b0; addr = 2'd0;
        step();
        nicEn = 1'b0;
        chk("in_pop_head", d_out, 64'h100);
        chk("in_ri_after_pop", PW'(net_ri), 64'h1);
        step();
        net_si = 1'b0;
        chk("in_fifth_taken", PW'(net_ri), 64'h0);
        cpu_read(2'd0, v); chk("in_drain0", v, 64'h101);
        cpu_read(2'd0, v); chk("in_drain1", v, 64'h102);
        cpu_read(2'd0, v); chk("in_drain2", v, 64'h103);
        cpu_read(2'd0, v); chk("in_drain3", v, 64'h105);

        // Back-to-back sends, then polarity gating
        net_ro = 1'b1; net_polarity = 1'b1;
        cpu_write(2'd2, 64'h11);
        chk("send_not_yet", PW'(net_so), 64'h0);
        cpu_write(2'd2, 64'h22);
        chk("send1_so", PW'(net_so), 64'h1); chk("send1_do", net_do, 64'h11);
        step();
        chk("send2_so", PW'(net_so), 64'h1); chk("send2_do", net_do, 64'h22);
        step();
        chk("send_idle_so", PW'(net_so), 64'h0); chk("send_hold_do", net_do, 64'h22);
        net_polarity = 1'b0;
        cpu_write(2'd2, 64'h33);
        cpu_write(2'd2, 64'h44);
        repeat (3) step();
        chk("pol_low_so", PW'(net_so), 64'h0);
        cpu_read(2'd3, v); chk("pol_low_count", v, 64'h4);
        net_polarity = 1'b1;
        step(); chk("pol_send_33", net_do, 64'h33);
        step(); chk("pol_send_44", net_do, 64'h44);
        step();
        net_ro = 1'b0; net_polarity = 1'b0;

        // Full output FIFO drops writes and sets sticky drop
        for (int k = 0; k < DEPTH; k++) cpu_write(2'd2, PW'(32'hA0 + k));
        cpu_write(2'd2, 64'hFF);
        cpu_read(2'd3, v); chk("drop_stat", v, 64'h8000_0000_0000_0009);
        cpu_read(2'd3, v); chk("drop_cleared", v, 64'h9);
        net_ro = 1'b1; net_polarity = 1'b1;
        got.delete();
        for (int k = 0; k < 6; k++) begin
            step();
            if (net_so) got.push_back(net_do);
        end
        chk("drop_sent_n", PW'(got.size()), 64'h4);
        for (int k = 0; k < 4; k++) begin
            v = (k < got.size()) ? got[k] : '1;
            chk("drop_sent_val", v, PW'(32'hA0 + k));
        end
        net_ro = 1'b0; net_polarity = 1'b0;

        // Reset with traffic queued both ways
        for (int k = 0; k < 3; k++) router_push(PW'(32'hC0 + k));
        for (int k = 0; k < 3; k++) cpu_write(2'd2, PW'(32'hB0 + k));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_so", PW'(net_so), 64'h0);
        chk("rstmid_ri", PW'(net_ri), 64'h1);
        chk("rstmid_dout", d_out, 64'h0);
        net_ro = 1'b1; net_polarity = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rstmid_no_send", PW'(net_so), 64'h0);
        end
        cpu_read(2'd1, v); chk("rstmid_in_stat", v, 64'h0);
        cpu_read(2'd3, v); chk("rstmid_out_stat", v, 64'h0);
        cpu_read(2'd0, v); chk("rstmid_in_data", v, 64'h0);
        net_ro = 1'b0; net_polarity = 1'b0;

        // Randomized soak; phases vary back-pressure to hit both full conditions
        for (int c = 0; c < 3000; c++) begin
            int unsigned ro_pct;
            ro_pct = (c < 1000) ? 15 : ((c < 2000) ? 85 : 50);
            reset        = ($urandom_range(0, 399) == 0);
            nicEn        = ($urandom_range(0, 99) < 60);
            nicEnWR      = ($urandom_range(0, 1) == 1);
            addr         = 2'($urandom_range(0, 3));
            if (nicEnWR && $urandom_range(0, 1) == 1) addr = 2'd2;
            d_in         = ($urandom_range(0, 9) == 0) ? '0 : {$urandom(), $urandom()};
            net_si       = ($urandom_range(0, 99) < ((c < 1000) ? 80 : 35));
            net_di       = ($urandom_range(0, 9) == 0) ? '0 : {$urandom(), $urandom()};
            net_ro       = ($urandom_range(0, 99) < ro_pct);
            net_polarity = ($urandom_range(0, 99) < 60);
            step();
        end
        reset = 1'b0; nicEn = 1'b0; net_si = 1'b0; net_ro = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
